// File: rtl/sram_fifo_ctrl.sv
// Synchronous FIFO controller wrapped around a one-write/one-read SRAM used as a circular buffer.
// Provides occupancy flags, one-cycle read latency and sticky overflow/underflow reporting.

module sync_dualport_sram #(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 4
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] waddr_i,
  input  logic [DATA_BITS-1:0] wdata_i,
  input  logic                 re_i,
  input  logic [ADDR_BITS-1:0] raddr_i,
  output logic [DATA_BITS-1:0] rdata_o
);
  logic [DATA_BITS-1:0] mem_q [2**ADDR_BITS];
  logic [DATA_BITS-1:0] rdata_q;

  // Non-blocking update gives read-before-write when both ports hit the same address.
  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

module sram_fifo_ctrl #(
  parameter int DATA_BITS = 8,
  parameter int ADDR_BITS = 4,
  parameter int AF_LEVEL  = (1 << ADDR_BITS) - 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic                 wr_en,
  input  logic [DATA_BITS-1:0] wr_data,
  input  logic                 rd_en,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 rd_valid,
  output logic [ADDR_BITS:0]   count,
  output logic                 empty,
  output logic                 full,
  output logic                 almost_full,
  output logic                 overflow,
  output logic                 underflow,
  input  logic                 clear_errors
);
  localparam logic [ADDR_BITS:0] DEPTH_C = (ADDR_BITS+1)'(1 << ADDR_BITS);
  localparam logic [ADDR_BITS:0] AF_C    = (ADDR_BITS+1)'(AF_LEVEL);

  logic [ADDR_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_BITS:0]   count_q, count_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 overflow_q, overflow_d;
  logic                 underflow_q, underflow_d;
  logic                 rd_acc, wr_acc, rd_ok, wr_ok;

  assign empty       = (count_q == '0);
  assign full        = (count_q == DEPTH_C);
  assign almost_full = (count_q >= AF_C);

  // Acceptance ignores flush for error reporting; the _ok versions actually move state.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);
  assign rd_ok  = rd_acc && !flush;
  assign wr_ok  = wr_acc && !flush;

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    rd_valid_d  = rd_ok;
    overflow_d  = (overflow_q  && !clear_errors) || (wr_en && !wr_acc && !flush);
    underflow_d = (underflow_q && !clear_errors) || (rd_en && !rd_acc && !flush);
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      rd_valid_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      rd_valid_q  <= rd_valid_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  sync_dualport_sram #(
    .DATA_BITS(DATA_BITS),
    .ADDR_BITS(ADDR_BITS)
  ) u_sram (
    .clk_i  (clk),
    .we_i   (wr_ok),
    .waddr_i(wr_ptr_q),
    .wdata_i(wr_data),
    .re_i   (rd_ok),
    .raddr_i(rd_ptr_q),
    .rdata_o(rd_data)
  );

  assign count     = count_q;
  assign rd_valid  = rd_valid_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;
endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// Self-checking bench for sram_fifo_ctrl: a queue model of the FIFO feeds a scoreboard of
// expected read words, popped whenever the DUT strobes rd_valid.

module tb_sram_fifo_ctrl;
  logic       clk = 1'b0;
  logic       reset, flush, wr_en, rd_en, clear_errors;
  logic [7:0] wr_data, rd_data;
  logic       rd_valid, empty, full, almost_full, overflow, underflow;
  logic [4:0] count;

  int checks = 0;
  int errors = 0;

  logic [7:0] model[$];
  logic [7:0] exp_q[$];
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;

  always #5 clk = ~clk;

  sram_fifo_ctrl #(.DATA_BITS(8), .ADDR_BITS(4), .AF_LEVEL(14)) dut (
    .clk(clk), .reset(reset), .flush(flush), .wr_en(wr_en), .wr_data(wr_data),
    .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid), .count(count),
    .empty(empty), .full(full), .almost_full(almost_full), .overflow(overflow),
    .underflow(underflow), .clear_errors(clear_errors)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model, then check DUT state on the falling edge.
  task automatic step(input logic we, input logic [7:0] wd, input logic re,
                      input logic fl = 1'b0, input logic ce = 1'b0, input logic rs = 1'b0);
    logic rd_acc, wr_acc, exp_vld;
    int   sz;
    wr_en = we; wr_data = wd; rd_en = re; flush = fl; clear_errors = ce; reset = rs;
    exp_vld = 1'b0;
    sz = model.size();
    if (rs) begin
      model.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (fl) begin
      model.delete();
      m_ovf = m_ovf && !ce;
      m_unf = m_unf && !ce;
    end else begin
      rd_acc = re && (sz > 0);
      wr_acc = we && ((sz < 16) || rd_acc);
      if (rd_acc) begin
        exp_q.push_back(model.pop_front());
        exp_vld = 1'b1;
      end
      if (wr_acc) model.push_back(wd);
      m_ovf = (m_ovf && !ce) || (we && !wr_acc);
      m_unf = (m_unf && !ce) || (re && !rd_acc);
    end
    @(posedge clk);
    @(negedge clk);
    chk("rd_valid", 32'(rd_valid), 32'(exp_vld));
    if (rd_valid === 1'b1) begin
      if (exp_q.size() == 0) chk("rd_spurious", 32'(1), 32'(0));
      else chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
    end
    exp_q.delete();
    chk("count", 32'(count), 32'(model.size()));
    chk("empty", 32'(empty), 32'(model.size() == 0));
    chk("full", 32'(full), 32'(model.size() == 16));
    chk("almost_full", 32'(almost_full), 32'(model.size() >= 14));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clear_errors = 1'b0; wr_data = '0;

    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("reset_count", 32'(count), 32'd0);
    chk("reset_empty", 32'(empty), 32'd1);

    // basic three-word write then back-to-back reads
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    chk("three_count", 32'(count), 32'd3);
    for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
    chk("drained_empty", 32'(empty), 32'd1);

    // fill to full, overflow, drain in order
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 8'(i), 1'b0);
      chk("af_edge", 32'(almost_full), 32'(i >= 13));
    end
    chk("full_set", 32'(full), 32'd1);
    step(1'b1, 8'hAA, 1'b0);
    chk("ovf_count", 32'(count), 32'd16);
    chk("ovf_set", 32'(overflow), 32'd1);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);

    // simultaneous read and write while full
    for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b1, 8'h55, 1'b1);
    chk("rw_full_data", 32'(rd_data), 32'h00);
    chk("rw_full_count", 32'(count), 32'd16);
    for (int i = 0; i < 16; i++) step(1'b0, 8'h00, 1'b1);

    // underflow and read/write on empty
    step(1'b0, 8'h00, 1'b1);
    chk("unf_set", 32'(underflow), 32'd1);
    step(1'b1, 8'h77, 1'b1);
    chk("empty_rw_count", 32'(count), 32'd1);
    step(1'b0, 8'h00, 1'b1);
    chk("empty_rw_data", 32'(rd_data), 32'h77);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("clear_unf", 32'(underflow), 32'd0);
    chk("clear_ovf", 32'(overflow), 32'd0);

    // interleaved traffic across pointer wrap
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 8'(i), 1'b0);
      step(1'b0, 8'h00, 1'b1);
    end

    // flush retains error flags
    for (int i = 0; i < 17; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h90 + i), 1'b0);
    step(1'b1, 8'hEE, 1'b1, 1'b1);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_vld", 32'(rd_valid), 32'd0);
    chk("flush_ovf_kept", 32'(overflow), 32'd1);
    chk("flush_unf_kept", 32'(underflow), 32'd1);
    step(1'b1, 8'h3C, 1'b0);
    step(1'b0, 8'h00, 1'b1);

    // reset mid-operation clears everything
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hA0 + i), 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_vld", 32'(rd_valid), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_unf", 32'(underflow), 32'd0);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_fifo_ctrl.md
Name: sram_fifo_ctrl

Overview:
Synchronous FIFO controller that sequences one internal sync_dualport_sram instance as a circular buffer. It owns the write and read pointers, the occupancy count and the full/empty/almost-full flags. It also keeps sticky overflow and underflow error flags. It sits between producer and consumer logic in the controller-emulation datapath, for example a packet capture path or a response staging path.

Parameters:
DATA_BITS, 8, width of each stored word.
ADDR_BITS, 4, SRAM address width; DEPTH = 2**ADDR_BITS entries (16).
AF_LEVEL, DEPTH-2 (14), count at or above which almost_full asserts; legal range 1..DEPTH.

Ports:
clk  input  1  system clock; all state updates on posedge.
reset  input  1  synchronous, active-high reset.
flush  input  1  synchronous pulse; empties the FIFO.
wr_en  input  1  write request; data is sampled in the same cycle.
wr_data  input  DATA_BITS  write data.
rd_en  input  1  read (pop) request.
rd_data  output  DATA_BITS  popped word; valid only while rd_valid=1.
rd_valid  output  1  one-cycle strobe one cycle after an accepted read.
count  output  ADDR_BITS+1  current occupancy, 0..DEPTH.
empty  output  1  count==0.
full  output  1  count==DEPTH.
almost_full  output  1  count>=AF_LEVEL.
overflow  output  1  sticky; a write was rejected.
underflow  output  1  sticky; a read was rejected.
clear_errors  input  1  synchronous clear of overflow and underflow.

Behaviour:
- Reset (synchronous, highest priority):
  - wr_ptr, rd_ptr, count, rd_valid, overflow and underflow all go to 0.
  - Hence empty=1, full=0, almost_full=0.
  - rd_data is the SRAM output register, is not reset, and is don't-care while rd_valid=0.
- Flush (priority below reset, above all requests):
  - Pointers and count go to 0 and rd_valid goes to 0 on the next edge.
  - wr_en and rd_en in the flush cycle are ignored and raise no error flags.
  - overflow and underflow are retained across a flush.
- Flags: empty, full and almost_full are combinational decodes of the count register, so they update in the cycle after the edge that changes count.
- Read acceptance: rd_ok = rd_en && !empty.
- Write acceptance: wr_ok = wr_en && (!full || rd_ok).
  - A write while full is accepted only with a simultaneous accepted read.
  - A write while empty is always accepted, even with rd_en asserted.
- Pointers:
  - ADDR_BITS wide; wrap naturally from DEPTH-1 to 0.
  - wr_ok increments wr_ptr; rd_ok increments rd_ptr.
  - SRAM write_addr = wr_ptr, read_addr = rd_ptr, write_en = wr_ok.
- Count: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither. Never exceeds DEPTH and never goes negative.
- Read latency is exactly 1 cycle:
  - If rd_ok in cycle N, then rd_valid=1 and rd_data=mem[rd_ptr(N)] in cycle N+1.
  - Back-to-back reads give one word per cycle.
- Read-during-write when full: wr_ptr==rd_ptr. The SRAM returns the old contents (read-before-write), which is the required behaviour. The new word is read DEPTH pops later.
- Empty with simultaneous rd_en and wr_en: the read is rejected (underflow set, no rd_valid), and the written word is readable from the next cycle.
- Error flags:
  - overflow sets when wr_en && !wr_ok && !flush.
  - underflow sets when rd_en && !rd_ok && !flush.
  - clear_errors clears both; a set in the same cycle as clear_errors wins.
- Reset mid-operation: rd_valid drops on the next edge even if a read was accepted in the reset cycle.

Test Plan:
- Reset, then write 0x11, 0x22, 0x33 on consecutive cycles -> count=3, empty=0. Then 3 back-to-back rd_en -> rd_valid high 3 cycles starting 1 cycle after the first rd_en, with data 0x11, 0x22, 0x33, ending at count=0 and empty=1.
- Write 0..15 -> almost_full rises when count=14 and full when count=16. An extra write of 0xAA -> count stays 16 and overflow=1. Read all 16 -> values 0..15, no 0xAA.
- Full FIFO holding 0..15, one cycle with rd_en and wr_en (0x55) -> rd_data=0 next cycle and count stays 16. Drain -> 1..15, then 0x55 last.
- Empty FIFO, rd_en alone -> no rd_valid and underflow=1. Then rd_en and wr_en (0x77) together -> count=1, no rd_valid. Next rd_en -> 0x77. clear_errors -> underflow=0.
- 40 interleaved write/read pairs, with data equal to an incrementing index, crossing the pointer wrap twice -> in-order data, count toggles between 0 and 1, no error flags.
- Fill 5 words, then assert flush together with rd_en -> next cycle count=0, empty=1, rd_valid=0, overflow and underflow unchanged. Repeat with reset instead of flush -> same result plus both error flags cleared.
